// File: rtl/id_ex_stage.sv
// ID/EX pipeline register plus the EX-stage operand network: forwarding from
// EX/MEM and MEM/WB, ALU operand selection and load-use stall/bubble control.
module id_ex_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [3:0]      id_alufn,
    input  logic            id_a_pc,
    input  logic            id_b_imm,
    input  logic            id_sh_imm,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_reg_write,
    input  logic            flush,
    input  logic            hold,
    input  logic            exm_reg_write,
    input  logic [4:0]      exm_rd,
    input  logic [XLEN-1:0] exm_result,
    input  logic            mwb_reg_write,
    input  logic [4:0]      mwb_rd,
    input  logic [XLEN-1:0] mwb_result,
    output logic            stall_id,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [4:0]      alu_shamt,
    output logic [3:0]      alu_alufn,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_pc,
    output logic [4:0]      ex_rd,
    output logic            ex_valid,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      alufn;
        logic            a_pc;
        logic            b_imm;
        logic            sh_imm;
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
    } ex_reg_t;

    ex_reg_t ex_q, ex_d, id_load;
    logic    load_use;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2;

    // A bubble is the all-zero record: invalid, no side effects, alufn = add.
    always_comb begin
        id_load           = '0;
        id_load.valid     = id_valid;
        id_load.pc        = id_pc;
        id_load.rs1_data  = id_rs1_data;
        id_load.rs2_data  = id_rs2_data;
        id_load.imm       = id_imm;
        id_load.rs1       = id_rs1;
        id_load.rs2       = id_rs2;
        id_load.rd        = id_rd;
        id_load.alufn     = id_alufn;
        id_load.a_pc      = id_a_pc;
        id_load.b_imm     = id_b_imm;
        id_load.sh_imm    = id_sh_imm;
        id_load.mem_read  = id_valid & id_mem_read;
        id_load.mem_write = id_valid & id_mem_write;
        id_load.reg_write = id_valid & id_reg_write;
    end

    assign load_use = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) & id_valid
                    & ((id_rs1 == ex_q.rd) | (id_rs2 == ex_q.rd));
    assign stall_id = load_use & ~flush & ~hold;

    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = '0;
        end else if (hold) begin
            ex_d = ex_q;
        end else if (stall_id) begin
            ex_d = '0;
        end else begin
            ex_d = id_load;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    function automatic logic [XLEN-1:0] forward(input logic [4:0] rs, input logic [XLEN-1:0] rf_val);
        if (exm_reg_write && (exm_rd != 5'd0) && (exm_rd == rs)) begin
            return exm_result;
        end else if (mwb_reg_write && (mwb_rd != 5'd0) && (mwb_rd == rs)) begin
            return mwb_result;
        end
        return rf_val;
    endfunction

    assign fwd_rs1 = forward(ex_q.rs1, ex_q.rs1_data);
    assign fwd_rs2 = forward(ex_q.rs2, ex_q.rs2_data);

    assign alu_a         = ex_q.a_pc   ? ex_q.pc       : fwd_rs1;
    assign alu_b         = ex_q.b_imm  ? ex_q.imm      : fwd_rs2;
    assign alu_shamt     = ex_q.sh_imm ? ex_q.imm[4:0] : fwd_rs2[4:0];
    assign alu_alufn     = ex_q.alufn;
    assign ex_store_data = fwd_rs2;
    assign ex_pc         = ex_q.pc;
    assign ex_rd         = ex_q.rd;
    assign ex_valid      = ex_q.valid;
    assign ex_mem_read   = ex_q.valid & ex_q.mem_read;
    assign ex_mem_write  = ex_q.valid & ex_q.mem_write;
    assign ex_reg_write  = ex_q.valid & ex_q.reg_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model predicts stall_id and
// the EX outputs per cycle; directed scenarios add hand-derived constant checks.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, id_valid, id_a_pc, id_b_imm, id_sh_imm;
    logic        id_mem_read, id_mem_write, id_reg_write, flush, hold;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alufn;
    logic        exm_reg_write, mwb_reg_write;
    logic [4:0]  exm_rd, mwb_rd;
    logic [31:0] exm_result, mwb_result;
    logic        stall_id, ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
    logic [31:0] alu_a, alu_b, ex_store_data, ex_pc;
    logic [4:0]  alu_shamt, ex_rd;
    logic [3:0]  alu_alufn;

    id_ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alufn(id_alufn),
        .id_a_pc(id_a_pc), .id_b_imm(id_b_imm), .id_sh_imm(id_sh_imm),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
        .flush(flush), .hold(hold),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
        .stall_id(stall_id), .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
        .alu_alufn(alu_alufn), .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd(ex_rd),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  fn;
        logic        apc, bimm, shimm, mr, mw, rw;
    } id_t;

    typedef struct {
        logic        exw;
        logic [4:0]  exrd;
        logic [31:0] exres;
        logic        mww;
        logic [4:0]  mwrd;
        logic [31:0] mwres;
    } fwd_t;

    typedef struct {
        logic [31:0] a, b, st, pc;
        logic [4:0]  sh, rd;
        logic [3:0]  fn;
        logic        v, mr, mw, rw;
    } out_t;

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;
    id_t  m;
    logic stall_q[$];
    out_t out_q[$];
    logic obs_stall;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_fwd(input fwd_t f, input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 5'd0) return rf;
        if (f.exw && f.exrd == rs) return f.exres;
        if (f.mww && f.mwrd == rs) return f.mwres;
        return rf;
    endfunction

    task automatic step(input id_t ins, input logic fl, input logic hd, input logic rs, input fwd_t f);
        logic  haz, es;
        out_t  e;
        logic [31:0] f1, f2;
        id_valid = ins.valid; id_pc = ins.pc; id_rs1_data = ins.rs1d; id_rs2_data = ins.rs2d;
        id_imm = ins.imm; id_rs1 = ins.rs1; id_rs2 = ins.rs2; id_rd = ins.rd; id_alufn = ins.fn;
        id_a_pc = ins.apc; id_b_imm = ins.bimm; id_sh_imm = ins.shimm;
        id_mem_read = ins.mr; id_mem_write = ins.mw; id_reg_write = ins.rw;
        flush = fl; hold = hd; rst = rs;
        exm_reg_write = f.exw; exm_rd = f.exrd; exm_result = f.exres;
        mwb_reg_write = f.mww; mwb_rd = f.mwrd; mwb_result = f.mwres;

        haz = m.valid && m.mr && m.rd != 5'd0 && ins.valid && (ins.rs1 == m.rd || ins.rs2 == m.rd);
        es  = haz && !fl && !hd;
        stall_q.push_back(es);
        #1;
        obs_stall = stall_id;
        check("stall_id", 32'(stall_id), 32'(stall_q.pop_front()));

        if (rs || fl || (!hd && es)) begin
            m = '{default: '0};
        end else if (!hd) begin
            m = ins;
            if (!ins.valid) begin
                m.mr = 1'b0; m.mw = 1'b0; m.rw = 1'b0;
            end
        end
        f1 = ref_fwd(f, m.rs1, m.rs1d);
        f2 = ref_fwd(f, m.rs2, m.rs2d);
        e.a  = m.apc ? m.pc : f1;
        e.b  = m.bimm ? m.imm : f2;
        e.sh = m.shimm ? m.imm[4:0] : f2[4:0];
        e.st = f2; e.pc = m.pc; e.rd = m.rd; e.fn = m.fn; e.v = m.valid;
        e.mr = m.valid & m.mr; e.mw = m.valid & m.mw; e.rw = m.valid & m.rw;
        out_q.push_back(e);

        @(posedge clk);
        #1;
        e = out_q.pop_front();
        check("alu_a", alu_a, e.a);
        check("alu_b", alu_b, e.b);
        check("alu_shamt", 32'(alu_shamt), 32'(e.sh));
        check("alu_alufn", 32'(alu_alufn), 32'(e.fn));
        check("ex_store_data", ex_store_data, e.st);
        check("ex_pc", ex_pc, e.pc);
        check("ex_rd", 32'(ex_rd), 32'(e.rd));
        check("ex_valid", 32'(ex_valid), 32'(e.v));
        check("ex_mem_read", 32'(ex_mem_read), 32'(e.mr));
        check("ex_mem_write", 32'(ex_mem_write), 32'(e.mw));
        check("ex_reg_write", 32'(ex_reg_write), 32'(e.rw));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        id_t  nop, i, ld;
        fwd_t f0, f;
        nop = '{default: '0};
        f0  = '{default: '0};
        m   = '{default: '0};

        rst = 1'b1; flush = 1'b0; hold = 1'b0;
        id_valid = 1'b0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_alufn = '0; id_a_pc = 1'b0; id_b_imm = 1'b0;
        id_sh_imm = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0; id_reg_write = 1'b0;
        exm_reg_write = 1'b0; exm_rd = '0; exm_result = '0;
        mwb_reg_write = 1'b0; mwb_rd = '0; mwb_result = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        step(nop, 1'b0, 1'b0, 1'b1, f0);
        check("rst_valid", 32'(ex_valid), 32'h0);
        check("rst_alu_a", alu_a, 32'h0);
        check("rst_stall", 32'(obs_stall), 32'h0);

        // Forward priority: EX/MEM beats MEM/WB, then regfile value
        i = nop; i.valid = 1'b1; i.rs1 = 5'd5; i.rs2 = 5'd6; i.rd = 5'd9;
        i.rs1d = 32'hAA; i.rs2d = 32'hBB; i.rw = 1'b1; i.pc = 32'h40;
        f = '{exw: 1'b1, exrd: 5'd5, exres: 32'h11, mww: 1'b1, mwrd: 5'd5, mwres: 32'h22};
        step(i, 1'b0, 1'b0, 1'b0, f);
        check("fwd_exm", alu_a, 32'h11);
        f.exw = 1'b0;
        step(nop, 1'b0, 1'b1, 1'b0, f);
        check("fwd_mwb", alu_a, 32'h22);
        step(nop, 1'b0, 1'b1, 1'b0, f0);
        check("fwd_rf", alu_a, 32'hAA);

        // x0 never forwarded
        i = nop; i.valid = 1'b1; i.rs1 = 5'd0; i.rs1d = 32'h0; i.rd = 5'd1; i.rw = 1'b1;
        f = '{exw: 1'b1, exrd: 5'd0, exres: 32'hDEAD, mww: 1'b1, mwrd: 5'd0, mwres: 32'hBEEF};
        step(i, 1'b0, 1'b0, 1'b0, f);
        check("x0_nofwd", alu_a, 32'h0);

        // Load-use: one bubble, then the consumer takes the load via MEM/WB
        ld = nop; ld.valid = 1'b1; ld.rs1 = 5'd2; ld.rd = 5'd7; ld.mr = 1'b1; ld.rw = 1'b1; ld.bimm = 1'b1;
        step(ld, 1'b0, 1'b0, 1'b0, f0);
        i = nop; i.valid = 1'b1; i.rs1 = 5'd7; i.rs2 = 5'd1; i.rd = 5'd8; i.rw = 1'b1;
        i.rs1d = 32'h5555; i.rs2d = 32'h1;
        step(i, 1'b0, 1'b0, 1'b0, f0);
        check("lu_stall", 32'(obs_stall), 32'h1);
        check("lu_bubble", 32'(ex_valid), 32'h0);
        f = '{exw: 1'b0, exrd: 5'd0, exres: 32'h0, mww: 1'b1, mwrd: 5'd7, mwres: 32'h1234};
        step(i, 1'b0, 1'b0, 1'b0, f);
        check("lu_nostall", 32'(obs_stall), 32'h0);
        check("lu_fwd", alu_a, 32'h1234);

        // Flush with a valid store, also carrying a load-use hazard
        step(ld, 1'b0, 1'b0, 1'b0, f0);
        i = nop; i.valid = 1'b1; i.rs1 = 5'd7; i.rs2 = 5'd3; i.mw = 1'b1; i.bimm = 1'b1;
        step(i, 1'b1, 1'b0, 1'b0, f0);
        check("flush_stall", 32'(obs_stall), 32'h0);
        check("flush_valid", 32'(ex_valid), 32'h0);
        check("flush_memw", 32'(ex_mem_write), 32'h0);

        // Operand select
        i = nop; i.valid = 1'b1; i.pc = 32'h100; i.imm = 32'h3000; i.apc = 1'b1; i.bimm = 1'b1;
        i.rd = 5'd4; i.rw = 1'b1; i.rs1 = 5'd0; i.rs2 = 5'd0;
        step(i, 1'b0, 1'b0, 1'b0, f0);
        check("auipc_a", alu_a, 32'h100);
        check("auipc_b", alu_b, 32'h3000);
        i = nop; i.valid = 1'b1; i.rs1 = 5'd2; i.imm = 32'h23; i.bimm = 1'b1; i.shimm = 1'b1;
        i.fn = 4'd1; i.rd = 5'd6; i.rw = 1'b1;
        step(i, 1'b0, 1'b0, 1'b0, f0);
        check("slli_sh", 32'(alu_shamt), 32'h3);
        i = nop; i.valid = 1'b1; i.rs1 = 5'd2; i.rs2 = 5'd4; i.rs2d = 32'h1F; i.fn = 4'd1;
        i.rd = 5'd6; i.rw = 1'b1;
        f = '{exw: 1'b1, exrd: 5'd4, exres: 32'h25, mww: 1'b0, mwrd: 5'd0, mwres: 32'h0};
        step(i, 1'b0, 1'b0, 1'b0, f);
        check("sll_sh", 32'(alu_shamt), 32'h5);
        check("sll_store", ex_store_data, 32'h25);

        // Hold freezes the register; reset in the middle clears it
        i = nop; i.valid = 1'b1; i.pc = 32'h200; i.rs1 = 5'd9; i.rs2 = 5'd10; i.rs1d = 32'h77;
        i.rs2d = 32'h88; i.rd = 5'd3; i.rw = 1'b1; i.fn = 4'd7;
        step(i, 1'b0, 1'b0, 1'b0, f0);
        for (int k = 0; k < 3; k++) begin
            i.pc = 32'h300 + 32'(k); i.rs1d = 32'(k); i.rd = 5'd11;
            step(i, 1'b0, 1'b1, 1'b0, f0);
            check("hold_pc", ex_pc, 32'h200);
            check("hold_a", alu_a, 32'h77);
            check("hold_rd", 32'(ex_rd), 32'd3);
        end
        step(i, 1'b0, 1'b1, 1'b1, f0);
        check("hold_rst_valid", 32'(ex_valid), 32'h0);
        check("hold_rst_pc", ex_pc, 32'h0);
        check("hold_rst_fn", 32'(alu_alufn), 32'h0);

        // Hold masks a hazard; it is re-evaluated when hold drops
        step(ld, 1'b0, 1'b0, 1'b0, f0);
        i = nop; i.valid = 1'b1; i.rs1 = 5'd1; i.rs2 = 5'd7; i.rd = 5'd12; i.rw = 1'b1;
        step(i, 1'b0, 1'b1, 1'b0, f0);
        check("hold_haz_stall", 32'(obs_stall), 32'h0);
        step(i, 1'b0, 1'b0, 1'b0, f0);
        check("hold_drop_stall", 32'(obs_stall), 32'h1);

        // Reset mid-hazard leaves no pending stall
        step(ld, 1'b0, 1'b0, 1'b0, f0);
        step(i, 1'b0, 1'b0, 1'b1, f0);
        step(i, 1'b0, 1'b0, 1'b0, f0);
        check("rst_haz_stall", 32'(obs_stall), 32'h0);

        // Random traffic on a small register set to provoke hazards and forwarding
        for (int n = 0; n < 80; n++) begin
            i.valid = 1'($urandom_range(0, 3) != 0);
            i.pc = $urandom; i.rs1d = $urandom; i.rs2d = $urandom; i.imm = $urandom;
            i.rs1 = 5'($urandom_range(0, 7)); i.rs2 = 5'($urandom_range(0, 7));
            i.rd = 5'($urandom_range(0, 7)); i.fn = 4'($urandom);
            i.apc = 1'($urandom); i.bimm = 1'($urandom); i.shimm = 1'($urandom);
            i.mr = 1'($urandom); i.mw = 1'($urandom); i.rw = 1'($urandom);
            f.exw = 1'($urandom); f.exrd = 5'($urandom_range(0, 7)); f.exres = $urandom;
            f.mww = 1'($urandom); f.mwrd = 5'($urandom_range(0, 7)); f.mwres = $urandom;
            step(i, 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 19) == 0), f);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and EX-stage operand network feeding the 32-bit ALU. The block captures decoded operands and control from ID and resolves data hazards by forwarding from EX/MEM and MEM/WB. It presents the ALU with `a`, `b`, `shamt` and `alufn`. It also detects load-use hazards, stalls ID/IF for one cycle, and inserts a bubble.

## Interface
- `XLEN`, default 32: datapath width.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `id_valid`  in  1: ID holds a real instruction.
- `id_pc`, `id_rs1_data`, `id_rs2_data`, `id_imm`  in  XLEN each: decoded values.
- `id_rs1`, `id_rs2`, `id_rd`  in  5 each: register indices.
- `id_alufn`  in  4: ALU function code.
- `id_a_pc`  in  1: operand A = PC (AUIPC/JAL).
- `id_b_imm`  in  1: operand B = immediate.
- `id_sh_imm`  in  1: shamt = imm[4:0], else rs2[4:0].
- `id_mem_read`, `id_mem_write`, `id_reg_write`  in  1 each: control.
- `flush`  in  1: branch/jump taken in EX; kill the instruction entering EX.
- `hold`  in  1: downstream (memory) stall; freeze the ID/EX register.
- `exm_reg_write`  in  1, `exm_rd`  in  5, `exm_result`  in  XLEN: EX/MEM forwarding source.
- `mwb_reg_write`  in  1, `mwb_rd`  in  5, `mwb_result`  in  XLEN: MEM/WB forwarding source.
- `stall_id`  out  1: load-use stall request to IF/ID.
- `alu_a`, `alu_b`  out  XLEN each; `alu_shamt`  out  5; `alu_alufn`  out  4: ALU inputs.
- `ex_store_data`  out  XLEN: forwarded rs2, used as store data.
- `ex_pc`  out  XLEN; `ex_rd`  out  5; `ex_valid`, `ex_mem_read`, `ex_mem_write`, `ex_reg_write`  out  1 each.

## Operation
- **Register update priority** (rising edge): `rst` > `flush` > `hold` > load-use bubble > normal load.
  - `rst`: all fields zero, `ex_valid`=0, alufn 4'b0000 (add).
  - `flush`: the register loads a bubble.
  - `hold`: the register keeps its contents.
  - Bubble: `ex_valid`=0, mem_read/mem_write/reg_write=0, rd=0, rs1=rs2=0; data fields don't-care (implementation zeroes them).
  - Normal load: all `id_*` fields are captured; `ex_valid` = `id_valid`. When `id_valid`=0, the control bits are captured as 0.
- **Load-use detection** (combinational): hazard when `ex_valid & ex_mem_read & ex_rd!=0 & id_valid` and (`id_rs1==ex_rd` or `id_rs2==ex_rd`).
  - `stall_id` = hazard & ~flush & ~hold.
  - When `stall_id`=1, the register loads a bubble.
  - rs2 is compared even for I-type instructions; conservative stalls are accepted.
- **Forwarding**, evaluated separately for registered rs1 and rs2:
  - If `exm_reg_write & exm_rd!=0 & exm_rd==rs`, use `exm_result`.
  - Else if `mwb_reg_write & mwb_rd!=0 & mwb_rd==rs`, use `mwb_result`.
  - Else use the registered regfile value.
  - The register file is write-before-read, so no WB-stage bypass is needed here.
- **Operand select**:
  - `alu_a` = `a_pc` ? pc : fwd_rs1.
  - `alu_b` = `b_imm` ? imm : fwd_rs2.
  - `alu_shamt` = `sh_imm` ? imm[4:0] : fwd_rs2[4:0].
  - `ex_store_data` = fwd_rs2 always.
  - `alu_alufn` is the registered alufn.
- Control outputs are forced 0 whenever `ex_valid`=0.

## Timing
- ID to EX latency: 1 cycle.
- Operand, forwarding and `stall_id` outputs are combinational from registered state plus same-cycle `exm_*`/`mwb_*`/`id_*`/`flush`/`hold`. There is no added latency.
- Load-use: exactly one bubble. On the next cycle the load sits in MEM and its result arrives via `mwb_result`.
- Reset values after `rst`: `ex_valid`=0, all control outputs 0, `alu_a`=`alu_b`=`ex_store_data`=0, `alu_shamt`=0, `alu_alufn`=0, `ex_pc`=0, `ex_rd`=0, `stall_id`=0 (given `id_valid`=0).
- Reset mid-hazard: `rst` clears the load in EX; no stall is pending afterwards.
- Simultaneous events:
  - `flush` with hazard: bubble, `stall_id`=0.
  - `hold` with hazard: register frozen, `stall_id`=0. The hazard is re-evaluated when hold drops.

## Test plan
- **Forward priority**: EX `add x5`, EX/MEM writes x5=0x11, MEM/WB writes x5=0x22, ID/EX rs1=x5 → `alu_a`=0x11. With `exm_reg_write`=0 → `alu_a`=0x22.
- **x0 never forwarded**: `exm_rd`=0 with `exm_result`=0xDEAD, `exm_reg_write`=1, rs1=x0 with regfile data 0 → `alu_a`=0.
- **Load-use**: `lw x7` in EX; ID `add x8,x7,x1` → `stall_id`=1 for one cycle, `ex_valid`=0 next cycle. The cycle after, the add is in EX and `alu_a` = `mwb_result` (0x1234).
- **Flush**: `flush`=1 with a valid ID `sw` → next cycle `ex_valid`=0, `ex_mem_write`=0.
  - `flush` plus load-use hazard → `stall_id`=0.
- **Operand select**: AUIPC with pc=0x100, imm=0x3000 → `alu_a`=0x100, `alu_b`=0x3000.
  - SLLI imm[4:0]=3 → `alu_shamt`=3.
  - SLL with fwd_rs2=0x25 → `alu_shamt`=5.
- **Hold and reset**: `hold`=1 for 3 cycles → EX outputs unchanged. `rst` in the middle → all outputs take their reset values next cycle.
